// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - accumulator instruction sequencer driving an external combinational ALU
// IDLE accepts one instruction; EXEC drives the ALU and registers the write-back.
module alu_sequencer #(
  parameter int CLAMP = 999,
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [3:0]       instr_op,
  input  logic [1:0]       instr_cond,
  input  logic [WIDTH-1:0] instr_operand,
  output logic [WIDTH-1:0] alu_in0,
  output logic [WIDTH-1:0] alu_in1,
  output logic [3:0]       alu_funct,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic [WIDTH-1:0] acc,
  output logic             plus_flag,
  output logic             minus_flag,
  output logic             sat_flag,
  output logic             done,
  output logic             skipped,
  output logic             illegal
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_NOT  = 4'd3;
  localparam logic [3:0] OP_TLT  = 4'd4;
  localparam logic [3:0] OP_TGT  = 4'd5;
  localparam logic [3:0] OP_MOV  = 4'd6;
  localparam logic [3:0] OP_CLRF = 4'd7;

  localparam logic signed [WIDTH-1:0] L_SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] L_SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] L_CLAMP_P = WIDTH'(CLAMP);
  localparam logic signed [WIDTH-1:0] L_CLAMP_N = -L_CLAMP_P;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_op;
  logic [1:0]       r_cond;
  logic [WIDTH-1:0] r_operand;
  logic [WIDTH-1:0] r_acc;
  logic             r_plus;
  logic             r_minus;
  logic             r_sat;
  logic             r_done;
  logic             r_skipped;
  logic             r_illegal;

  logic [WIDTH-1:0] w_acc_nxt;
  logic             w_plus_nxt;
  logic             w_minus_nxt;
  logic             w_sat_nxt;
  logic             w_done_nxt;
  logic             w_skipped_nxt;
  logic             w_illegal_nxt;
  logic             w_accept;
  logic             w_cond_ok;
  logic             w_sign;
  logic [WIDTH-1:0] w_ovf_val;
  logic [WIDTH-1:0] w_arith_val;
  logic [WIDTH-1:0] w_mov_val;

  function automatic logic [WIDTH-1:0] f_clamp(input logic [WIDTH-1:0] v);
    if ($signed(v) > L_CLAMP_P) begin
      return L_CLAMP_P;
    end else if ($signed(v) < L_CLAMP_N) begin
      return L_CLAMP_N;
    end
    return v;
  endfunction

  // Saturation direction follows the sign the true result must have had.
  always_comb begin
    w_sign = r_acc[WIDTH-1];
    if (r_op == OP_MUL) begin
      w_sign = r_acc[WIDTH-1] ^ r_operand[WIDTH-1];
    end
    w_ovf_val   = alu_overflow ? (w_sign ? L_SAT_MIN : L_SAT_MAX) : alu_out;
    w_arith_val = f_clamp(w_ovf_val);
    w_mov_val   = f_clamp(r_operand);
  end

  always_comb begin
    w_cond_ok = 1'b0;
    case (r_cond)
      2'b00:   w_cond_ok = 1'b1;
      2'b01:   w_cond_ok = r_plus;
      2'b10:   w_cond_ok = r_minus;
      default: w_cond_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt   = r_state;
    instr_ready   = 1'b0;
    alu_in1       = '0;
    alu_funct     = 4'd0;
    w_acc_nxt     = r_acc;
    w_plus_nxt    = r_plus;
    w_minus_nxt   = r_minus;
    w_sat_nxt     = r_sat;
    w_done_nxt    = 1'b0;
    w_skipped_nxt = 1'b0;
    w_illegal_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_in1     = r_operand;
        if (r_op <= OP_TGT) begin
          alu_funct = r_op;
        end
        w_state_nxt = ST_IDLE;
        w_done_nxt  = 1'b1;
        if (r_op > OP_CLRF) begin
          w_illegal_nxt = 1'b1;
        end else if (!w_cond_ok) begin
          w_skipped_nxt = 1'b1;
        end else begin
          case (r_op)
            OP_ADD, OP_SUB, OP_MUL: begin
              w_acc_nxt = w_arith_val;
              if (alu_overflow || (w_arith_val != w_ovf_val)) begin
                w_sat_nxt = 1'b1;
              end
            end
            OP_NOT: w_acc_nxt = alu_out;
            OP_TLT, OP_TGT: begin
              w_plus_nxt  = ~alu_zero;
              w_minus_nxt = alu_zero;
            end
            OP_MOV: begin
              w_acc_nxt = w_mov_val;
              if (w_mov_val != r_operand) begin
                w_sat_nxt = 1'b1;
              end
            end
            OP_CLRF: begin
              w_plus_nxt  = 1'b0;
              w_minus_nxt = 1'b0;
              w_sat_nxt   = 1'b0;
            end
            default: ;
          endcase
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_accept = instr_valid && instr_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_op      <= 4'd0;
      r_cond    <= 2'b00;
      r_operand <= '0;
      r_acc     <= '0;
      r_plus    <= 1'b0;
      r_minus   <= 1'b0;
      r_sat     <= 1'b0;
      r_done    <= 1'b0;
      r_skipped <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      if (w_accept) begin
        r_op      <= instr_op;
        r_cond    <= instr_cond;
        r_operand <= instr_operand;
      end
      r_acc     <= w_acc_nxt;
      r_plus    <= w_plus_nxt;
      r_minus   <= w_minus_nxt;
      r_sat     <= w_sat_nxt;
      r_done    <= w_done_nxt;
      r_skipped <= w_skipped_nxt;
      r_illegal <= w_illegal_nxt;
    end
  end

  assign alu_in0    = r_acc;
  assign acc        = r_acc;
  assign plus_flag  = r_plus;
  assign minus_flag = r_minus;
  assign sat_flag   = r_sat;
  assign done       = r_done;
  assign skipped    = r_skipped;
  assign illegal    = r_illegal;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed bench for alu_sequencer with a behavioural 11-bit ALU
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  instr_op;
  logic [1:0]  instr_cond;
  logic [10:0] instr_operand;
  logic [10:0] alu_in0;
  logic [10:0] alu_in1;
  logic [3:0]  alu_funct;
  logic [10:0] alu_out;
  logic        alu_zero;
  logic        alu_overflow;
  logic [10:0] acc;
  logic        plus_flag;
  logic        minus_flag;
  logic        sat_flag;
  logic        done;
  logic        skipped;
  logic        illegal;

  int total = 0;
  int bad   = 0;

  logic [10:0] cap_in0;
  logic [10:0] cap_in1;
  logic [3:0]  cap_funct;
  logic        cap_ovf;
  logic        cap_ready;

  int m_a;
  int m_b;
  int m_full;

  alu_sequencer #(.CLAMP(999), .WIDTH(11)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_cond(instr_cond), .instr_operand(instr_operand),
    .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_funct(alu_funct),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .acc(acc), .plus_flag(plus_flag), .minus_flag(minus_flag), .sat_flag(sat_flag),
    .done(done), .skipped(skipped), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Reference ALU: exact integer result, truncated to 11 bits, overflow if it did not fit.
  always_comb begin
    m_a    = int'($signed(alu_in0));
    m_b    = int'($signed(alu_in1));
    m_full = 0;
    case (alu_funct)
      4'd0:    m_full = m_a + m_b;
      4'd1:    m_full = m_a - m_b;
      4'd2:    m_full = m_a * m_b;
      4'd3:    m_full = ~m_a;
      4'd4:    m_full = (m_a < m_b) ? 1 : 0;
      4'd5:    m_full = (m_a > m_b) ? 1 : 0;
      default: m_full = 0;
    endcase
    alu_out      = m_full[10:0];
    alu_overflow = (alu_funct <= 4'd2) && ((m_full > 1023) || (m_full < -1024));
    alu_zero     = (alu_out == 11'd0);
  end

  task automatic chkw(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Offer at a falling edge, capture the ALU drive during EXEC, return at the done cycle.
  task automatic issue(input logic [3:0] op, input logic [1:0] cond, input logic [10:0] opnd);
    @(negedge clk);
    instr_valid   = 1'b1;
    instr_op      = op;
    instr_cond    = cond;
    instr_operand = opnd;
    @(negedge clk);
    instr_valid = 1'b0;
    cap_in0     = alu_in0;
    cap_in1     = alu_in1;
    cap_funct   = alu_funct;
    cap_ovf     = alu_overflow;
    cap_ready   = instr_ready;
    @(negedge clk);
  endtask

  initial begin
    reset         = 1'b1;
    instr_valid   = 1'b0;
    instr_op      = 4'd0;
    instr_cond    = 2'b00;
    instr_operand = 11'd0;
    repeat (2) @(negedge clk);
    chkw("rst_acc", acc, 11'd0);
    chk1("rst_plus", plus_flag, 1'b0);
    chk1("rst_minus", minus_flag, 1'b0);
    chk1("rst_sat", sat_flag, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_ready", instr_ready, 1'b1);
    chkw("rst_in1", alu_in1, 11'd0);
    reset = 1'b0;

    issue(4'd6, 2'b00, 11'd500);
    chkw("mov500_acc", acc, 11'd500);
    chk1("mov500_sat", sat_flag, 1'b0);
    issue(4'd0, 2'b00, 11'd600);
    chk1("add600_exec_ready", cap_ready, 1'b0);
    chkw("add600_in0", cap_in0, 11'd500);
    chkw("add600_in1", cap_in1, 11'd600);
    chkw("add600_funct", {7'd0, cap_funct}, 11'd0);
    chk1("add600_done", done, 1'b1);
    chk1("add600_ready", instr_ready, 1'b1);
    chkw("add600_acc", acc, 11'd999);
    chk1("add600_sat", sat_flag, 1'b1);
    @(negedge clk);
    chk1("done_one_cycle", done, 1'b0);

    issue(4'd6, 2'b00, 11'(-40));
    chkw("mov_m40_acc", acc, 11'(-40));
    issue(4'd2, 2'b00, 11'd30);
    chk1("mul_ovf", cap_ovf, 1'b1);
    chkw("mul_funct", {7'd0, cap_funct}, 11'd2);
    chkw("mul_acc", acc, 11'(-999));
    chk1("mul_sat", sat_flag, 1'b1);
    issue(4'd7, 2'b00, 11'd0);
    chk1("clrf_sat", sat_flag, 1'b0);
    chkw("clrf_acc", acc, 11'(-999));

    issue(4'd6, 2'b00, 11'd5);
    issue(4'd5, 2'b00, 11'd3);
    chk1("tgt_plus", plus_flag, 1'b1);
    chk1("tgt_minus", minus_flag, 1'b0);
    chkw("tgt_acc", acc, 11'd5);
    issue(4'd0, 2'b10, 11'd7);
    chk1("cond10_done", done, 1'b1);
    chk1("cond10_skipped", skipped, 1'b1);
    chkw("cond10_acc", acc, 11'd5);
    issue(4'd0, 2'b01, 11'd7);
    chk1("cond01_skipped", skipped, 1'b0);
    chkw("cond01_acc", acc, 11'd12);

    issue(4'd1, 2'b00, 11'd20);
    chkw("sub_acc", acc, 11'(-8));
    chk1("sub_sat", sat_flag, 1'b0);
    issue(4'd4, 2'b00, 11'(-8));
    chk1("tlt_eq_plus", plus_flag, 1'b0);
    chk1("tlt_eq_minus", minus_flag, 1'b1);
    issue(4'd0, 2'b11, 11'd5);
    chk1("cond11_skipped", skipped, 1'b1);
    chkw("cond11_acc", acc, 11'(-8));
    issue(4'd3, 2'b00, 11'd0);
    chkw("not_acc", acc, 11'd7);
    chk1("not_sat", sat_flag, 1'b0);
    issue(4'd6, 2'b00, 11'd1023);
    chkw("mov_max_acc", acc, 11'd999);
    chk1("mov_max_sat", sat_flag, 1'b1);
    issue(4'd6, 2'b00, 11'(-1024));
    chkw("mov_min_acc", acc, 11'(-999));

    @(negedge clk);
    instr_valid   = 1'b1;
    instr_op      = 4'd6;
    instr_cond    = 2'b00;
    instr_operand = 11'd1;
    chk1("b2b_ready_c0", instr_ready, 1'b1);
    @(negedge clk);
    chk1("b2b_ready_c1", instr_ready, 1'b0);
    instr_op      = 4'd0;
    @(negedge clk);
    chk1("b2b_ready_c2", instr_ready, 1'b1);
    chk1("b2b_done_c2", done, 1'b1);
    chkw("b2b_acc_c2", acc, 11'd1);
    @(negedge clk);
    chk1("b2b_ready_c3", instr_ready, 1'b0);
    chk1("b2b_done_c3", done, 1'b0);
    @(negedge clk);
    chk1("b2b_ready_c4", instr_ready, 1'b1);
    chk1("b2b_done_c4", done, 1'b1);
    chkw("b2b_acc_c4", acc, 11'd2);
    @(negedge clk);
    chk1("b2b_ready_c5", instr_ready, 1'b0);
    instr_valid = 1'b0;
    @(negedge clk);
    chk1("b2b_done_c6", done, 1'b1);
    chkw("b2b_acc_c6", acc, 11'd3);

    issue(4'd9, 2'b00, 11'd5);
    chkw("ill_funct", {7'd0, cap_funct}, 11'd0);
    chk1("ill_done", done, 1'b1);
    chk1("ill_flag", illegal, 1'b1);
    chk1("ill_skipped", skipped, 1'b0);
    chkw("ill_acc", acc, 11'd3);
    chk1("ill_minus", minus_flag, 1'b1);
    chk1("ill_sat", sat_flag, 1'b1);

    issue(4'd6, 2'b00, 11'd50);
    chkw("mov50_acc", acc, 11'd50);
    @(negedge clk);
    instr_valid   = 1'b1;
    instr_op      = 4'd0;
    instr_operand = 11'd100;
    @(negedge clk);
    instr_valid = 1'b0;
    chk1("rstx_exec_ready", instr_ready, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chkw("rstx_acc", acc, 11'd0);
    chk1("rstx_ready", instr_ready, 1'b1);
    chk1("rstx_done", done, 1'b0);
    chk1("rstx_minus", minus_flag, 1'b0);
    @(negedge clk);
    chk1("rstx_done_after", done, 1'b0);
    chkw("rstx_acc_after", acc, 11'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Initiator side of the 11-bit ALU interface. Accepts accumulator instructions over a valid/ready handshake and drives the combinational ALU's operand/funct ports. Captures the ALU's out/zero/overflow back into an accumulator, with clamping and test flags. Sits between the instruction fetch/decode stage and the `alu` instance, and owns the architectural acc register and the +/- condition flags.

Parameters:
CLAMP, 999, magnitude limit; written acc values are clamped to [-CLAMP, +CLAMP].
WIDTH, 11, datapath width; must equal the ALU operand width.

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
instr_valid  input  1  instruction present
instr_ready  output  1  block can accept an instruction this cycle
instr_op  input  4  0 ADD, 1 SUB, 2 MUL, 3 NOT, 4 TLT, 5 TGT, 6 MOV, 7 CLRF, 8-15 illegal
instr_cond  input  2  00 always, 01 only if plus_flag, 10 only if minus_flag, 11 never
instr_operand  input  WIDTH  two's-complement operand
alu_in0  output  WIDTH  ALU operand A (always acc)
alu_in1  output  WIDTH  ALU operand B
alu_funct  output  4  ALU function code
alu_out  input  WIDTH  ALU result
alu_zero  input  1  ALU zero flag
alu_overflow  input  1  ALU overflow flag
acc  output  WIDTH  accumulator
plus_flag  output  1  last test true
minus_flag  output  1  last test false
sat_flag  output  1  sticky: a result was saturated or clamped
done  output  1  one-cycle pulse: instruction retired
skipped  output  1  valid with done: condition false, no state change
illegal  output  1  valid with done: illegal opcode, no state change

Behaviour:
- Reset (sync, overrides everything, including mid-EXEC): state=IDLE, acc=0, all flags=0, done/skipped/illegal=0, latched instruction dropped.
- FSM states:
  - IDLE: instr_ready=1. On instr_valid&instr_ready (cycle N), latch op/cond/operand and go to EXEC.
  - EXEC (cycle N+1): instr_ready=0. Drive the ALU. At the clock edge ending N+1, the write-back below is registered and the FSM returns to IDLE.
- Timing: in cycle N+2, acc and flags hold new values, done=1, and instr_ready=1. Maximum throughput is one instruction per 2 cycles. instr_valid held high continuously is accepted in cycles N, N+2, N+4, ...
- ALU drive:
  - alu_in0=acc always.
  - In EXEC, alu_in1=operand_q; alu_funct=op_q for ops 0-5, else 0.
  - In IDLE, alu_in1=0 and alu_funct=0.
- Condition: evaluated on flags at EXEC. When false, or cond=11, the instruction still takes EXEC; write-back is suppressed; done=1 and skipped=1.
- Write-back:
  - ADD/SUB/MUL, overflow handling: if alu_overflow, the raw result saturates to max/min of WIDTH. Sign rule: ADD uses acc[MSB]; SUB uses acc[MSB]; MUL uses acc[MSB]^operand[MSB].
  - ADD/SUB/MUL, clamp: the result is then clamped to ±CLAMP. sat_flag is set if saturation or clamping changed the value.
  - NOT: acc=alu_out, no clamp.
  - TLT/TGT: acc unchanged. alu_zero=0 gives plus_flag=1, minus_flag=0; alu_zero=1 gives plus_flag=0, minus_flag=1.
  - MOV: acc=clamp(operand), with sat_flag set if clamped; ALU result ignored.
  - CLRF: plus_flag=minus_flag=sat_flag=0.
  - Illegal ops: no state change; done=1, illegal=1.
- Flag invariants: plus_flag and minus_flag are never both 1. After reset both are 0, so cond 01 and 10 skip until a test executes.
- done/skipped/illegal are registered pulses, exactly one cycle wide, and 0 in all other cycles.

Test Plan:
- Reset, MOV 500, ADD 600 -> done at N+2 of ADD, acc=999, sat_flag=1; ALU observed with in0=500, in1=600, funct=0 during EXEC.
- MOV -40, MUL 30 -> ALU overflow asserted (-1200); acc=-999, sat_flag=1. Then CLRF -> sat_flag=0, acc unchanged.
- MOV 5, TGT 3 -> plus_flag=1, minus_flag=0, acc=5. Then ADD cond=10 operand 7 -> skipped=1, acc=5. Then ADD cond=01 operand 7 -> acc=12.
- instr_valid held high for 3 instructions (MOV 1, ADD 1, ADD 1) -> instr_ready alternates 1/0, accepts in cycles 0/2/4, done in 2/4/6, final acc=3.
- opcode 9 -> done=1, illegal=1, acc and flags unchanged; ALU funct=0 during EXEC.
- reset asserted during EXEC of ADD 100 with acc=50 -> next cycle acc=0, state IDLE, instr_ready=1, no done pulse.
